// File: rtl/spi_cmd_regfile_pkg.sv
// Shared definitions for the SPI command register file.
//   - state_e      : command-interpreter states
//   - CMD_RW_BIT   : bit of the command byte selecting read (1) / write (0)
//   - CMD_ADDR_W   : width of the address field in the command byte
//   - ptr_inc()    : address auto-increment with wrap at the bank size
package spi_cmd_regfile_pkg;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_ADDR_W = 7;

    typedef enum logic [1:0] {
        ST_CMD     = 2'd0,
        ST_WDATA   = 2'd1,
        ST_RDATA   = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    // Next register address within a frame; wraps from the last register to 0.
    function automatic logic [CMD_ADDR_W-1:0] ptr_inc(input logic [CMD_ADDR_W-1:0] p,
                                                      input int num_regs);
        if (int'(p) == num_regs - 1) return '0;
        return p + 1'b1;
    endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8-bit register bank.
//   clk_i, rst_n_i : clock, synchronous active-low reset (clears every register)
//   we_i/waddr_i/wdata_i : write port, committed at posedge
//   raddr_i -> rdata_o   : asynchronous read port (0 for out-of-range addresses)
//   regs_flat_o          : whole bank, reg i at [8*i +: 8]
module spi_reg_bank
    import spi_cmd_regfile_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    we_i,
    input  logic [CMD_ADDR_W-1:0]   waddr_i,
    input  logic [7:0]              wdata_i,
    input  logic [CMD_ADDR_W-1:0]   raddr_i,
    output logic [7:0]              rdata_o,
    output logic [8*NUM_REGS-1:0]   regs_flat_o
);

    logic [NUM_REGS-1:0][7:0] regs_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                regs_q[g] <= 8'h00;
            end else if (we_i && waddr_i == CMD_ADDR_W'(g)) begin
                regs_q[g] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr_i == CMD_ADDR_W'(i)) rdata_o = regs_q[i];
        end
    end

    assign regs_flat_o = regs_q;

endmodule

// File: rtl/spi_cmd_regfile.sv
// SPI command interpreter + register bank.
// Each CS frame: first byte {RW, ADDR[6:0]}, then write data (RW=0) or read
// dummies (RW=1). The address auto-increments per data byte, wrapping at NUM_REGS.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   in_data_i/in_val_i/in_rdy_o : byte stream from the SPI receiver
//   cs_idle_i               : synchronized CS, 1 = frame boundary
//   tx_data_o/tx_val_o/tx_rdy_i : read bytes to the SPI transmitter
//   regs_flat_o             : register bank, reg i at [8*i +: 8]
//   wr_strobe_o/wr_addr_o   : one-cycle pulse + address for each register write
//   err_o, err_clr_i        : sticky error (bad address or tx overrun) and its clear
module spi_cmd_regfile
    import spi_cmd_regfile_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [7:0]              in_data_i,
    input  logic                    in_val_i,
    output logic                    in_rdy_o,
    input  logic                    cs_idle_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_val_o,
    input  logic                    tx_rdy_i,
    output logic [8*NUM_REGS-1:0]   regs_flat_o,
    output logic                    wr_strobe_o,
    output logic [CMD_ADDR_W-1:0]   wr_addr_o,
    output logic                    err_o,
    input  logic                    err_clr_i
);

    state_e                  state_q;
    logic [CMD_ADDR_W-1:0]   ptr_q;
    logic [7:0]              tx_data_q;
    logic                    tx_val_q;
    logic                    wr_strobe_q;
    logic [CMD_ADDR_W-1:0]   wr_addr_q;
    logic                    err_q;

    logic                    accept;
    logic [CMD_ADDR_W-1:0]   cmd_addr;
    logic [CMD_ADDR_W-1:0]   ptr_nx;
    logic [CMD_ADDR_W-1:0]   raddr;
    logic [7:0]              rdata;
    logic                    bank_we;

    // Never back-pressure the receiver inside a frame.
    assign in_rdy_o = ~cs_idle_i;
    assign accept   = in_val_i & ~cs_idle_i;
    assign cmd_addr = in_data_i[CMD_ADDR_W-1:0];
    assign ptr_nx   = ptr_inc(ptr_q, NUM_REGS);

    // Single read port: command byte reads the addressed register, each dummy
    // in RDATA prefetches the one after the current pointer.
    assign raddr   = (state_q == ST_CMD) ? cmd_addr : ptr_nx;
    assign bank_we = accept && (state_q == ST_WDATA);

    spi_reg_bank #(.NUM_REGS(NUM_REGS)) u_bank (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .we_i        (bank_we),
        .waddr_i     (ptr_q),
        .wdata_i     (in_data_i),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .regs_flat_o (regs_flat_o)
    );

    // Later assignments in this block take priority: a reload beats the
    // tx_rdy clear, a new error beats err_clr, frame end beats everything.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_CMD;
            ptr_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_val_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (tx_rdy_i && tx_val_q) tx_val_q <= 1'b0;
            if (err_clr_i) err_q <= 1'b0;

            if (accept) begin
                case (state_q)
                    ST_CMD: begin
                        ptr_q <= cmd_addr;
                        if (int'(cmd_addr) >= NUM_REGS) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DISCARD;
                        end else if (!in_data_i[CMD_RW_BIT]) begin
                            state_q <= ST_WDATA;
                        end else begin
                            tx_data_q <= rdata;
                            tx_val_q  <= 1'b1;
                            state_q   <= ST_RDATA;
                        end
                    end
                    ST_WDATA: begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= ptr_q;
                        ptr_q       <= ptr_nx;
                    end
                    ST_RDATA: begin
                        // Previous byte never taken by the transmitter: overrun.
                        if (tx_val_q && !tx_rdy_i) err_q <= 1'b1;
                        ptr_q     <= ptr_nx;
                        tx_data_q <= rdata;
                        tx_val_q  <= 1'b1;
                    end
                    default: ; // DISCARD: drop bytes until frame end
                endcase
            end

            if (cs_idle_i) begin
                state_q  <= ST_CMD;
                tx_val_q <= 1'b0;
            end
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_val_o    = tx_val_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
module tb_spi_cmd_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_val;
    logic        in_rdy;
    logic        cs_idle;
    logic [7:0]  tx_data;
    logic        tx_val;
    logic        tx_rdy;
    logic [63:0] regs_flat;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic        err;
    logic        err_clr;

    int total = 0;
    int fails = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    spi_cmd_regfile #(.NUM_REGS(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_data_i   (in_data),
        .in_val_i    (in_val),
        .in_rdy_o    (in_rdy),
        .cs_idle_i   (cs_idle),
        .tx_data_o   (tx_data),
        .tx_val_o    (tx_val),
        .tx_rdy_i    (tx_rdy),
        .regs_flat_o (regs_flat),
        .wr_strobe_o (wr_strobe),
        .wr_addr_o   (wr_addr),
        .err_o       (err),
        .err_clr_i   (err_clr)
    );

    always @(negedge clk) if (wr_strobe === 1'b1) strobes++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b;
        in_val  = 1'b1;
        tick();
        in_val  = 1'b0;
        in_data = 8'h00;
    endtask

    task automatic frame_end();
        cs_idle = 1'b1;
        tick();
        cs_idle = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cs_idle = 1'b1; in_val = 1'b0; in_data = 8'h00;
        tx_rdy = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_tx_val", tx_val, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_strobe", wr_strobe, 0);
        chk("rst_regs", regs_flat, 64'h0);
        chk("rdy_idle", in_rdy, 0);

        // 1: single write
        cs_idle = 1'b0;
        #1 chk("rdy_frame", in_rdy, 1);
        send(8'h02);
        chk("t1_no_early_strobe", wr_strobe, 0);
        send(8'hA5);
        chk("t1_strobe", wr_strobe, 1);
        chk("t1_wr_addr", wr_addr, 2);
        chk("t1_regs", regs_flat, 64'h0000_0000_00A5_0000);
        frame_end();
        chk("t1_strobe_cnt", strobes, 1);
        chk("t1_strobe_pulse", wr_strobe, 0);

        // 2: preload r3/r4, then burst read from 3
        send(8'h03); send(8'h11); send(8'h22); frame_end();
        chk("t2_preload", regs_flat, 64'h0000_0022_11A5_0000);
        send(8'h83);
        chk("t2_val0", tx_val, 1);
        chk("t2_data0", tx_data, 8'h11);
        tx_rdy = 1'b1;
        send(8'hFF);
        chk("t2_val1", tx_val, 1);
        chk("t2_data1", tx_data, 8'h22);
        send(8'hFF);
        chk("t2_data2", tx_data, 8'h00);
        tick();
        tx_rdy = 1'b0;
        chk("t2_val_clr", tx_val, 0);
        chk("t2_err", err, 0);
        frame_end();

        // 3: write burst wrapping 7 -> 0
        strobes = 0;
        send(8'h07); send(8'hAA);
        chk("t3_addr7", wr_addr, 7);
        send(8'hBB);
        chk("t3_addr0", wr_addr, 0);
        frame_end();
        chk("t3_strobe_cnt", strobes, 2);
        chk("t3_regs", regs_flat, 64'hAA00_0022_11A5_00BB);

        // 4: out-of-range address
        strobes = 0;
        send(8'h10);
        chk("t4_err", err, 1);
        send(8'h55);
        frame_end();
        chk("t4_no_strobe", strobes, 0);
        chk("t4_regs", regs_flat, 64'hAA00_0022_11A5_00BB);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_err_clr", err, 0);
        send(8'h01); send(8'h5A); frame_end();
        chk("t4_recover", regs_flat, 64'hAA00_0022_11A5_5ABB);
        // new error beats a simultaneous clear
        err_clr = 1'b1; send(8'h90); err_clr = 1'b0;
        chk("t4_err_prio", err, 1);
        frame_end();
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // 5: frame ending right after the command byte
        strobes = 0;
        send(8'h01); frame_end();
        chk("t5_no_strobe", strobes, 0);
        chk("t5_regs", regs_flat, 64'hAA00_0022_11A5_5ABB);
        send(8'h81);
        chk("t5_read", tx_data, 8'h5A);
        chk("t5_val", tx_val, 1);
        frame_end();
        chk("t5_val_end", tx_val, 0);

        // 6: overrun with tx_rdy held low, then reset mid-frame
        send(8'h82);
        chk("t6_data0", tx_data, 8'hA5);
        send(8'h00);
        chk("t6_err", err, 1);
        send(8'h00);
        chk("t6_data_latest", tx_data, 8'h22);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6_rst_regs", regs_flat, 64'h0);
        chk("t6_rst_val", tx_val, 0);
        chk("t6_rst_data", tx_data, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_strobe", wr_strobe, 0);
        send(8'h00); send(8'h77);
        chk("t6_post_rst_write", regs_flat, 64'h0000_0000_0000_0077);
        frame_end();

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
